// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and the buffered fetch entry type for the fetch stage
package fetch_pkg;
  localparam int PC_STEP = 4;
  localparam int FETCH_FIFO_DEPTH = 2;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small circular buffer of fetched {pc, instruction} entries with flush
//   clk, reset (async active-low) | push/din: write tail | pop: drop head
//   flush: empty the buffer (wins over push/pop) | head: oldest entry | count: occupancy
//   Push and pop in the same cycle are legal when full.
module fetch_fifo import fetch_pkg::*; #(
  parameter int DEPTH = FETCH_FIFO_DEPTH,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  din,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= nxt(wr_q);
      if (pop) rd_q <= nxt(rd_q);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr_q] <= din;
  assign head = mem[rd_q];
  assign count = count_q;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner feeding a synchronous imem and a 2-entry decode buffer
//   clk, reset (async active-low) | imem_address/imem_instruction: memory side
//   redirect/redirect_target: branch/jump PC load with flush
//   if_valid/if_ready/if_pc/if_instruction: handshake to decode (pc/instr read 0 when empty)
//   FETCH_ALIGN_CHECK_EN: adds sticky fetch_misaligned; misaligned redirect halts fetch.
//   Without it the target's low two bits are ignored.
module instruction_fetch import fetch_pkg::*; #(
  parameter int              BITS     = 32,
  parameter logic [BITS-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [BITS-1:0] imem_address,
  input  logic [BITS-1:0] imem_instruction,
  input  logic            redirect,
  input  logic [BITS-1:0] redirect_target,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic            fetch_misaligned,
`endif
  output logic            if_valid,
  input  logic            if_ready,
  output logic [BITS-1:0] if_pc,
  output logic [BITS-1:0] if_instruction
);
  localparam int CW = $clog2(FETCH_FIFO_DEPTH + 1);
  localparam int OW = CW + 1;
  logic [BITS-1:0] pc_q, req_pc_q, target;
  logic req_valid_q, pop, issue, halted;
  logic [CW-1:0] count;
  logic [OW-1:0] occupancy;
  fetch_entry_t head;
`ifdef FETCH_ALIGN_CHECK_EN
  logic misaligned_q;
  assign target = redirect_target;
  assign halted = misaligned_q;
  assign fetch_misaligned = misaligned_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) misaligned_q <= 1'b0;
    else if (redirect && redirect_target[1:0] != 2'b00) misaligned_q <= 1'b1;
`else
  assign target = redirect_target & ~BITS'(3);
  assign halted = 1'b0;
`endif
  assign pop = if_valid & if_ready;
  // Credit check: entries held after this edge, counting the response still in flight.
  assign occupancy = {1'b0, count} + OW'(req_valid_q) - OW'(pop);
  assign issue = !halted && occupancy < OW'(FETCH_FIFO_DEPTH);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc_q <= RESET_PC;
      req_valid_q <= 1'b0;
      req_pc_q <= '0;
    end else if (redirect) begin
      pc_q <= target;
      req_valid_q <= 1'b0;
    end else if (issue) begin
      pc_q <= pc_q + BITS'(PC_STEP);
      req_valid_q <= 1'b1;
      req_pc_q <= pc_q;
    end else begin
      req_valid_q <= 1'b0;
    end
  // A redirect drops the response arriving this edge along with the buffered entries.
  fetch_fifo #(.DEPTH(FETCH_FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (req_valid_q & ~redirect),
    .pop   (pop),
    .flush (redirect),
    .din   (fetch_entry_t'{pc: req_pc_q, instruction: imem_instruction}),
    .head  (head),
    .count (count)
  );
  assign imem_address = pc_q;
  assign if_valid = count != '0;
  assign if_pc = if_valid ? head.pc : '0;
  assign if_instruction = if_valid ? head.instruction : '0;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed + random bench; expected fetch stream kept as a program-order queue
module tb_instruction_fetch;
  logic clk = 0, reset = 1, redirect = 0, if_ready = 0;
  logic [31:0] redirect_target = 0, imem_instruction = 0;
  logic [31:0] imem_address, if_pc, if_instruction;
  logic if_valid;
`ifdef FETCH_ALIGN_CHECK_EN
  logic fetch_misaligned;
`endif
  int errors = 0, checks = 0, pops = 0;
  logic [31:0] exp_q[$];
  logic [31:0] next_pc = 0, e_pc;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk              (clk),
    .reset            (reset),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .redirect         (redirect),
    .redirect_target  (redirect_target),
`ifdef FETCH_ALIGN_CHECK_EN
    .fetch_misaligned (fetch_misaligned),
`endif
    .if_valid         (if_valid),
    .if_ready         (if_ready),
    .if_pc            (if_pc),
    .if_instruction   (if_instruction)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000000F;
    if (a == 32'h4) return 32'h000000FF;
    if (a == 32'h8) return 32'h00000FFF;
    return {a[15:0], ~a[31:16]};
  endfunction

  // Synchronous instruction memory: data for the sampled address appears after the edge.
  always @(posedge clk) imem_instruction <= mem(imem_address);

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // Monitor: every accepted entry must be the next instruction in program order.
  // A redirect restarts program order at the (aligned) target after any same-cycle pop.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      next_pc = 32'h0;
    end else begin
      while (exp_q.size() < 4) begin
        exp_q.push_back(next_pc);
        next_pc = next_pc + 32'd4;
      end
      if (if_valid && if_ready) begin
        e_pc = exp_q.pop_front();
        chk("stream_pc", if_pc, e_pc);
        chk("stream_instr", if_instruction, mem(e_pc));
        pops++;
      end
      if (redirect) begin
        exp_q.delete();
        next_pc = redirect_target & ~32'h3;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 0;
    redirect = 0;
    @(negedge clk);
    #2 reset = 1;
  endtask

  initial begin
    #2 reset = 0;
    #1;
    chk("rst_valid", if_valid, 0);
    chk("rst_addr", imem_address, 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_instr", if_instruction, 0);
    @(negedge clk);
    if_ready = 1;
    #2 reset = 1;
    // Reset release: issue at E1, valid after E2, back-to-back after that.
    @(posedge clk); #1;
    chk("e1_valid", if_valid, 0);
    chk("e1_addr", imem_address, 4);
    @(posedge clk); #1;
    chk("e2_valid", if_valid, 1);
    chk("e2_pc", if_pc, 0);
    chk("e2_instr", if_instruction, 32'hF);
    @(posedge clk); #1;
    chk("e3_pc", if_pc, 4);
    chk("e3_instr", if_instruction, 32'hFF);
    @(posedge clk); #1;
    chk("e4_pc", if_pc, 8);
    chk("e4_instr", if_instruction, 32'hFFF);
    // Back-pressure from reset.
    if_ready = 0;
    do_reset();
    repeat (6) @(posedge clk);
    #1;
    chk("bp_addr", imem_address, 8);
    chk("bp_valid", if_valid, 1);
    chk("bp_head", if_pc, 0);
    if_ready = 1;
    #1 chk("bp_out0", if_pc, 0);
    @(posedge clk); #1;
    chk("bp_out1", if_pc, 4);
    @(posedge clk); #1;
    chk("bp_out2", if_pc, 8);
    chk("bp_out2_valid", if_valid, 1);
    // Redirect with a full buffer.
    if_ready = 0;
    do_reset();
    repeat (5) @(posedge clk);
    #1 redirect = 1;
    redirect_target = 32'h4;
    @(posedge clk); #1 redirect = 0;
    chk("rf_valid_r", if_valid, 0);
    @(posedge clk); #1;
    chk("rf_valid_r1", if_valid, 0);
    @(posedge clk); #1;
    chk("rf_valid_r2", if_valid, 1);
    chk("rf_pc", if_pc, 4);
    chk("rf_instr", if_instruction, 32'hFF);
    if_ready = 1;
    repeat (6) @(posedge clk);
    // Redirect coincident with a pop of pc 0.
    do_reset();
    repeat (2) @(posedge clk);
    #1 chk("rp_head", if_pc, 0);
    redirect = 1;
    redirect_target = 32'h40;
    @(posedge clk); #1 redirect = 0;
    chk("rp_valid_r", if_valid, 0);
    repeat (2) @(posedge clk);
    #1 chk("rp_pc", if_pc, 32'h40);
    // PC wrap.
    redirect = 1;
    redirect_target = 32'hFFFF_FFF8;
    @(posedge clk); #1 redirect = 0;
    repeat (2) @(posedge clk);
    #1 chk("wrap_pc0", if_pc, 32'hFFFF_FFF8);
    @(posedge clk); #1 chk("wrap_pc1", if_pc, 32'hFFFF_FFFC);
    @(posedge clk); #1 chk("wrap_pc2", if_pc, 32'h0);
    // Reset asserted between edges mid-stream.
    repeat (3) @(posedge clk);
    #3 reset = 0;
    #1;
    chk("mid_valid", if_valid, 0);
    chk("mid_addr", imem_address, 0);
    chk("mid_pc", if_pc, 0);
    chk("mid_instr", if_instruction, 0);
    @(negedge clk);
    #2 reset = 1;
    repeat (4) @(posedge clk);
    // Redirect to a misaligned target.
    #1 redirect = 1;
    redirect_target = 32'h6;
    @(posedge clk); #1 redirect = 0;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_flag", fetch_misaligned, 1);
    repeat (4) begin
      @(posedge clk); #1;
      chk("mis_halt", if_valid, 0);
    end
    do_reset();
    #1 chk("mis_cleared", fetch_misaligned, 0);
`else
    repeat (2) @(posedge clk);
    #1;
    chk("mis_pc", if_pc, 4);
    chk("mis_instr", if_instruction, 32'hFF);
`endif
    // Random phase: back-pressure and aligned redirects, including wrap targets.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if_ready = $urandom_range(0, 3) != 0;
      redirect = $urandom_range(0, 29) == 0;
      redirect_target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 4
                                                   : 32'($urandom_range(0, 255)) * 4;
    end
    redirect = 0;
    repeat (4) @(posedge clk);
    #1 chk("progress", 32'(pops > 1500), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
